// File: rtl/if_stage.sv
// Purpose : RISC-V instruction-fetch stage; owns the PC, fetches words over req/ack, buffers one word for decode.
// Latency : one cycle from imem_ack to inst_valid; zero-wait memory with inst_ready=1 sustains one instruction per cycle.
// Backpr. : inst_ready=0 freezes the held word and withholds new requests; an outstanding request is never retracted before its ack.
//
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   imem_req/imem_addr        word fetch request; address held stable until imem_ack
//   imem_ack/imem_rdata       memory completion and returned instruction word
//   redirect_valid/_pc        taken branch/jump target from execute
//   inst_valid/inst_ready     handshake toward decode
//   inst_out/inst_pc          held instruction word (op_value) and its address
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [31:0] inst_pc_q, inst_pc_d;

    logic        req;
    logic        ack;
    logic [31:0] target;

    // A request is live in FETCH and DROP, and in HOLD only when decode is
    // taking the held word this cycle (so the next word can land in its place).
    assign req    = (state_q == S_FETCH) || (state_q == S_DROP) ||
                    ((state_q == S_HOLD) && inst_ready);
    assign ack    = req && imem_ack;
    assign target = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_pc_d = pending_pc_q;
        inst_valid_d = inst_valid_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;

        if (redirect_valid) begin
            inst_valid_d = 1'b0;
            inst_out_d   = NOP_INST;
            if (!req || ack) begin
                // Nothing in flight (or it completes now and is thrown away):
                // jump straight to the target.
                pc_d    = target;
                state_d = S_FETCH;
            end else begin
                // Memory still owes a word for the old address; the address must
                // stay put until it arrives, so park the target until then.
                pending_pc_d = target;
                state_d      = S_DROP;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (ack) begin
                        inst_out_d   = imem_rdata;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + 32'd4;
                        state_d      = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        if (ack) begin
                            inst_out_d   = imem_rdata;
                            inst_pc_d    = pc_q;
                            inst_valid_d = 1'b1;
                            pc_d         = pc_q + 32'd4;
                        end else begin
                            // Held word consumed, replacement not back yet; the
                            // request on pc continues from FETCH.
                            inst_valid_d = 1'b0;
                            inst_out_d   = NOP_INST;
                            state_d      = S_FETCH;
                        end
                    end
                end
                S_DROP: begin
                    if (ack) begin
                        pc_d    = pending_pc_q;
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            pending_pc_q <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_out_q   <= NOP_INST;
            inst_pc_q    <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_pc_q <= pending_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign imem_req   = req;
    assign imem_addr  = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst_out   = inst_out_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    int          n_acc   = 0;
    int          wcnt    = 0;
    int          wtgt    = 0;
    int          wait_n  = 0;
    bit          rand_wait = 1'b0;
    bit          prev_req = 1'b0;
    bit          prev_ack = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] next_exp = 32'h0;

    // Memory image: addr 0 holds addi x1,x0,5; other words are a bijective
    // function of the address so every word is distinguishable.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic pick_wait();
        wtgt = rand_wait ? int'($urandom_range(0, 3)) : wait_n;
    endtask

    // Expected program-order stream: sequential words from the last target.
    task automatic top_up();
        while (exp_q.size() < 2) begin
            exp_q.push_back(next_exp);
            next_exp = next_exp + 32'd4;
        end
    endtask

    // One clock cycle: drive decode/redirect inputs, then play memory.
    task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
        @(posedge clk);
        if (prev_req && prev_ack) begin
            wcnt = 0;
            pick_wait();
        end else if (prev_req) begin
            wcnt++;
        end else begin
            wcnt = 0;
        end
        #1;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rv) begin
            exp_q.delete();
            next_exp = {rpc[31:2], 2'b00};
        end
        top_up();
        #1;
        imem_ack   = imem_req && (wcnt >= wtgt);
        imem_rdata = mem_word(imem_addr);
        prev_req   = imem_req;
        prev_ack   = imem_ack;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        exp_q.delete();
        next_exp = 32'h0;
        top_up();
        wcnt     = 0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        pick_wait();
        @(posedge clk);
        #2;
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_out",   inst_out, NOP);
        chk("rst_pc",    inst_pc, 32'h0);
        rst = 1'b0;
    endtask

    // Monitor / scoreboard: sampled mid-cycle, away from the rising edge.
    bit          m_prev_hold = 1'b0;
    bit          m_prev_wait = 1'b0;
    logic [31:0] m_out, m_pc, m_addr;
    logic [31:0] e;

    always @(negedge clk) begin
        if (!rst) begin
            chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
            if (!inst_valid) chk("nop_when_empty", inst_out, NOP);
            if (m_prev_hold) begin
                chk("stall_valid", 32'(inst_valid), 32'd1);
                chk("stall_out", inst_out, m_out);
                chk("stall_pc", inst_pc, m_pc);
            end
            if (m_prev_wait) begin
                chk("req_kept", 32'(imem_req), 32'd1);
                chk("addr_kept", imem_addr, m_addr);
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                e = exp_q.pop_front();
                chk("sb_pc", inst_pc, e);
                chk("sb_inst", inst_out, mem_word(e));
                n_acc++;
            end
        end
        m_prev_hold = !rst && inst_valid && !inst_ready && !redirect_valid;
        m_prev_wait = !rst && imem_req && !imem_ack;
        m_out  = inst_out;
        m_pc   = inst_pc;
        m_addr = imem_addr;
    end

    int acc_start;

    initial begin
        rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;

        // Zero-wait memory, decode always ready: back-to-back words.
        wait_n = 0;
        do_reset();
        step(1, 0, 0);
        chk("t1_first_valid", 32'(inst_valid), 32'd0);
        chk("t1_first_addr", imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0);
            chk("t1_valid", 32'(inst_valid), 32'd1);
            chk("t1_pc", inst_pc, 32'(i * 4));
        end

        // Three wait states on the first fetch.
        wait_n = 3;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0);
            chk("t2_req", 32'(imem_req), 32'd1);
            chk("t2_addr", imem_addr, 32'h0);
            chk("t2_ack", 32'(imem_ack), 32'(i == 3));
        end
        step(1, 0, 0);
        chk("t2_valid", 32'(inst_valid), 32'd1);
        chk("t2_out", inst_out, 32'h0050_0093);
        chk("t2_pc", inst_pc, 32'h0);

        // Decode stalls with the word from 8 held.
        wait_n = 0;
        do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0);
            chk("t3_pc", inst_pc, 32'h8);
            chk("t3_out", inst_out, mem_word(32'h8));
            chk("t3_req", 32'(imem_req), 32'd0);
        end
        step(1, 0, 0);
        chk("t3_next_addr", imem_addr, 32'hC);

        // Redirect while the fetch of 0x10 is waiting on memory.
        wait_n = 2;
        step(1, 1, 32'h0000_0103);
        chk("t4_req_a", 32'(imem_req), 32'd1);
        chk("t4_addr_a", imem_addr, 32'h10);
        step(0, 0, 0);
        chk("t4_addr_b", imem_addr, 32'h10);
        chk("t4_valid_b", 32'(inst_valid), 32'd0);
        wait_n = 0;
        step(0, 0, 0);
        chk("t4_addr_c", imem_addr, 32'h10);
        chk("t4_ack_c", 32'(imem_ack), 32'd1);
        step(1, 0, 0);
        chk("t4_valid_d", 32'(inst_valid), 32'd0);
        chk("t4_addr_d", imem_addr, 32'h100);

        // Redirect while decode is stalled.
        step(0, 0, 0);
        chk("t5_pc", inst_pc, 32'h100);
        chk("t5_req", 32'(imem_req), 32'd0);
        step(0, 1, 32'h0000_0200);
        chk("t5_valid_still", 32'(inst_valid), 32'd1);
        step(1, 0, 0);
        chk("t5_valid_drop", 32'(inst_valid), 32'd0);
        chk("t5_out_nop", inst_out, NOP);
        chk("t5_addr", imem_addr, 32'h200);

        // PC wraps from the top of the address space.
        step(1, 1, 32'hFFFF_FFFC);
        chk("t6_pc_200", inst_pc, 32'h200);
        step(1, 0, 0);
        chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        step(1, 0, 0);
        chk("t6_pc_top", inst_pc, 32'hFFFF_FFFC);
        chk("t6_addr_wrap", imem_addr, 32'h0);

        // Reset while a request is outstanding.
        wait_n = 3;
        step(1, 0, 0);
        chk("t7_req", 32'(imem_req), 32'd1);
        chk("t7_ack", 32'(imem_ack), 32'd0);
        do_reset();

        // Randomized traffic against the scoreboard.
        rand_wait = 1'b1;
        do_reset();
        acc_start = n_acc;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : ($urandom & 32'h0000_0FFF);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, tgt);
            if (i == 2000) do_reset();
        end
        chk("rand_throughput", 32'((n_acc - acc_start) >= 300), 32'd1);

        step(0, 0, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
